// File: rtl/operand_fwd_unit.sv
// Operand forwarding and load-use hazard unit for the rv32i pipeline.
// Selects each source operand from the regfile, EX/MEM, MEM/WB or a one-cycle
// load-data bypass. A load-use wait FSM holds the pipeline until dcache data
// returns. A saturating counter records the number of stalled cycles.
module operand_fwd_unit #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic [NUM_SRC*REG_W-1:0] i_src_addr,
    input  logic [NUM_SRC-1:0]       i_src_used,
    input  logic [NUM_SRC*XLEN-1:0]  i_rf_data,
    input  logic                     i_exm_valid,
    input  logic [REG_W-1:0]         i_exm_rd,
    input  logic                     i_exm_is_load,
    input  logic [XLEN-1:0]          i_exm_data,
    input  logic                     i_mwb_valid,
    input  logic [REG_W-1:0]         i_mwb_rd,
    input  logic [XLEN-1:0]          i_mwb_data,
    input  logic                     i_dmem_resp,
    input  logic [XLEN-1:0]          i_dmem_rdata,
    output logic [NUM_SRC*2-1:0]     o_fwd_sel,
    output logic [NUM_SRC*XLEN-1:0]  o_src_data,
    output logic                     o_stall,
    output logic [CNT_W-1:0]         o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_BYPASS    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EXM = 2'd1;
    localparam logic [1:0] SEL_MWB = 2'd2;
    localparam logic [1:0] SEL_BYP = 2'd3;

    state_t             r_state;
    logic [REG_W-1:0]   r_byp_rd;
    logic [XLEN-1:0]    r_byp_data;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic [NUM_SRC-1:0] w_load_hit;
    logic               w_haz;
    logic               w_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_port
        logic [REG_W-1:0] w_addr;
        logic [XLEN-1:0]  w_rf;
        logic [1:0]       w_sel;
        logic [XLEN-1:0]  w_data;

        assign w_addr = i_src_addr[g*REG_W +: REG_W];
        assign w_rf   = i_rf_data[g*XLEN +: XLEN];

        // This port reads the destination of the load sitting in EX/MEM.
        assign w_load_hit[g] = i_src_used[g] && (w_addr == i_exm_rd);

        // Forwarding priority: load bypass > EX/MEM ALU result > MEM/WB > regfile; x0 never forwarded.
        always_comb begin
            w_sel = SEL_RF;
            if (i_src_used[g] && (w_addr != '0)) begin
                if ((r_state == ST_BYPASS) && (w_addr == r_byp_rd))
                    w_sel = SEL_BYP;
                else if (i_exm_valid && !i_exm_is_load && (w_addr == i_exm_rd))
                    w_sel = SEL_EXM;
                else if (i_mwb_valid && (w_addr == i_mwb_rd))
                    w_sel = SEL_MWB;
            end
        end

        // Operand mux driven by the select.
        always_comb begin
            unique case (w_sel)
                SEL_EXM: w_data = i_exm_data;
                SEL_MWB: w_data = i_mwb_data;
                SEL_BYP: w_data = r_byp_data;
                default: w_data = w_rf;
            endcase
        end

        assign o_fwd_sel[g*2 +: 2]     = w_sel;
        assign o_src_data[g*XLEN +: XLEN] = w_data;
    end

    assign w_haz = i_exm_valid && i_exm_is_load && (i_exm_rd != '0) && (|w_load_hit);

    // Stall decode: a new hazard stalls from IDLE or BYPASS, LOAD_WAIT always stalls, flush wins.
    always_comb begin
        w_stall = 1'b0;
        if (!i_flush) begin
            unique case (r_state)
                ST_IDLE:      w_stall = w_haz;
                ST_BYPASS:    w_stall = w_haz;
                ST_LOAD_WAIT: w_stall = 1'b1;
                default:      w_stall = 1'b0;
            endcase
        end
    end

    // Load-use FSM, bypass capture and saturating stall counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_byp_rd       <= '0;
            r_byp_data     <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;

            if (i_flush) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    // BYPASS re-uses the IDLE detection so back-to-back load-use chains re-enter.
                    ST_IDLE, ST_BYPASS: begin
                        if (w_haz) begin
                            r_byp_rd <= i_exm_rd;
                            if (i_dmem_resp) begin
                                r_byp_data <= i_dmem_rdata;
                                r_state    <= ST_BYPASS;
                            end else begin
                                r_state    <= ST_LOAD_WAIT;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_LOAD_WAIT: begin
                        if (i_dmem_resp) begin
                            r_byp_data <= i_dmem_rdata;
                            r_state    <= ST_BYPASS;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_stall_cycles = r_stall_cycles;

endmodule
